agex_md_stage: RTL and testbench
================================

# agex_md_stage

Address-generation/execute stage of the 5-stage pipeline. It sits between the decode latch and the memory stage. It performs single-cycle ALU, branch and address work and iterative multi-cycle MUL/DIVU/REMU. It produces the AGEX latch consumed by the memory stage and a registered branch redirect to fetch. It stalls decode with a ready signal while the iterative unit is busy.

## Interface
- DBITS, 32, data/PC width
- REGNOBITS, 5, register-number width
- MD_ITERS, 32, iterations per MUL/DIVU/REMU (one bit per cycle)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; state clears while 0
- de_valid  in  1  decode latch holds a real instruction
- de_inst  in  32  raw instruction, passed through
- de_pc  in  DBITS  instruction PC
- de_op  in  `IOPBITS  decoded op enum (OP_* in define.vh)
- de_inst_count  in  DBITS  sequence number, passed through
- de_rs1_val, de_rs2_val, de_imm  in  DBITS  operands, sign-extended immediate
- de_wr_reg  in  1, de_wregno  in  REGNOBITS  destination write enable and number
- de_ready  out  1  stage accepts de_* this cycle (combinational from FSM state)
- agex_valid, agex_inst, agex_pc, agex_op, agex_inst_count  out  latch fields, passed through
- agex_aluout  out  DBITS  result or memory address
- agex_wr_reg, agex_wregno  out  destination write enable and number
- agex_is_load, agex_is_store  out  1  LW / SW
- agex_wr_val  out  DBITS  store data (rs2)
- br_redirect  out  1  registered one-cycle pulse: taken control transfer
- br_target  out  DBITS  redirect PC; 0 when br_redirect=0

## Operation
- Single-cycle ops:
  - ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU; I-forms use de_imm as operand B. Shifts use B[4:0].
  - LUI gives imm. AUIPC gives pc+imm.
- LW/SW: aluout = rs1+imm. is_load or is_store set. wr_val = rs2.
- Branches BEQ/BNE/BLT/BGE/BLTU/BGEU:
  - Predicted not-taken.
  - If taken: br_redirect=1, br_target = pc+imm.
  - wr_reg forced 0.
- JAL: target = pc+imm. JALR: target = (rs1+imm) & ~1. Both always redirect; aluout = pc+4.
- All arithmetic is modulo 2^DBITS. Carries are discarded.
- Bubble rule: whenever agex_valid=0, agex_wr_reg, agex_is_load and agex_is_store are 0. The memory stage writes on is_store unqualified.
- Wrong-path squash: in the cycle br_redirect=1, de_ready=1 and the incoming instruction is dropped.
  - The latch receives a bubble.
  - No MD operation starts.
- MD FSM:
  - IDLE:
    - de_ready=1.
    - A valid MUL/DIVU/REMU accepted at edge E0 captures its operands and moves to BUSY with cnt=0. The latch gets a bubble at E0.
  - BUSY:
    - de_ready=0.
    - One shift-add (MUL) or restoring-subtract (DIVU/REMU) step per edge.
    - After cnt reaches MD_ITERS-1, the state moves to DONE.
  - DONE:
    - de_ready=1.
    - At the next edge the latch receives the MD result with valid=1 and the state returns to IDLE.
    - A new instruction presented in the DONE cycle is accepted at that same edge. If it is MD, the state goes directly to BUSY.
- MUL returns the low DBITS bits of the product. DIVU and REMU are unsigned.
- Divide by zero: DIVU returns 0xFFFFFFFF and REMU returns the dividend, with no trap. The FSM timing is unchanged.

## Timing
- Non-MD op accepted at edge N appears on agex_* after edge N; br_redirect is asserted in the same cycle.
- MD op accepted at edge E0:
  - Latch holds a bubble after edges E0..E0+32.
  - Result appears after edge E0+33.
  - de_ready is low for 32 cycles.
- Throughput: 1 instruction/cycle for non-MD ops; 33 cycles per MD op.
- Reset values:
  - All agex_* outputs 0.
  - br_redirect 0, br_target 0.
  - FSM IDLE, cnt 0, so de_ready=1 immediately after release.
- Reset asserted mid-BUSY:
  - The operation is aborted and no result is ever emitted.
  - Outputs clear asynchronously, without waiting for a clock edge.
- de_valid=0 in IDLE produces a bubble; the FSM stays in IDLE.

## Test plan
- ADD rs1=5, rs2=7, wregno=3 -> after one edge: aluout=12, wr_reg=1, wregno=3, valid=1. Next cycle de_valid=0 -> valid=0, wr_reg=0.
- SW rs1=0x100, imm=8, rs2=0xDEADBEEF -> aluout=0x108, is_store=1, wr_val=0xDEADBEEF. Following bubble -> is_store=0.
- BEQ rs1=rs2=4, pc=0x40, imm=-8 -> br_redirect=1, br_target=0x38 for exactly one cycle. ADD presented in that cycle -> latch valid=0. BNE with the same operands -> no redirect.
- MUL 0xFFFFFFFF*3 -> de_ready low for 32 cycles, then aluout=0xFFFFFFFD, valid=1 at E0+33. Back-to-back ADD presented in DONE -> appears at E0+34.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFFFFFF. REMU 9/0 -> 9. Each result arrives at E0+33.
- Reset driven low at BUSY cycle 10 -> all outputs 0 without a clock edge. After release de_ready=1, no MD result appears, and ADD 1+1 -> 2 next edge.

Source files
------------

// File: rtl/agex_md_stage.sv
// agex_md_stage -- address-generation / execute stage of the 5-stage pipeline.
//
// Sits between the decode latch and the memory stage. It does single-cycle
// ALU, branch and address work, plus an iterative one-bit-per-cycle unit for
// MUL / DIVU / REMU. Its outputs are the AGEX latch and a registered branch
// redirect to fetch.
//
// Ports
//   clk, reset            rising-edge clock; asynchronous active-low reset
//   de_*                  decode latch: valid, inst, pc, op, inst_count,
//                         rs1/rs2 values, sign-extended imm, wr_reg, wregno
//   de_ready              stage accepts de_* this cycle
//   agex_*                AGEX latch consumed by the memory stage
//   br_redirect/br_target registered one-cycle taken-transfer pulse and PC
//
// The op encoding lives in agex_pkg so the decoder and any bench share it.

package agex_pkg;
  localparam int IOPBITS = 6;

  typedef enum logic [IOPBITS-1:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI,
    OP_SRAI, OP_SLTI, OP_SLTIU, OP_LUI, OP_AUIPC, OP_LW, OP_SW, OP_BEQ,
    OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR, OP_MUL,
    OP_DIVU, OP_REMU
  } op_e;
endpackage

module agex_md_stage
  import agex_pkg::*;
#(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int MD_ITERS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [31:0]          de_inst,
  input  logic [DBITS-1:0]     de_pc,
  input  logic [IOPBITS-1:0]   de_op,
  input  logic [DBITS-1:0]     de_inst_count,
  input  logic [DBITS-1:0]     de_rs1_val,
  input  logic [DBITS-1:0]     de_rs2_val,
  input  logic [DBITS-1:0]     de_imm,
  input  logic                 de_wr_reg,
  input  logic [REGNOBITS-1:0] de_wregno,
  output logic                 de_ready,
  output logic                 agex_valid,
  output logic [31:0]          agex_inst,
  output logic [DBITS-1:0]     agex_pc,
  output logic [IOPBITS-1:0]   agex_op,
  output logic [DBITS-1:0]     agex_inst_count,
  output logic [DBITS-1:0]     agex_aluout,
  output logic                 agex_wr_reg,
  output logic [REGNOBITS-1:0] agex_wregno,
  output logic                 agex_is_load,
  output logic                 agex_is_store,
  output logic [DBITS-1:0]     agex_wr_val,
  output logic                 br_redirect,
  output logic [DBITS-1:0]     br_target
);

  localparam int CW = (MD_ITERS > 1) ? $clog2(MD_ITERS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  // Everything the latch and the redirect register carry; an all-zero value
  // is a bubble, which keeps wr_reg/is_load/is_store low whenever valid is.
  typedef struct packed {
    logic                 valid;
    logic [31:0]          inst;
    logic [DBITS-1:0]     pc;
    logic [IOPBITS-1:0]   op;
    logic [DBITS-1:0]     inst_count;
    logic [DBITS-1:0]     aluout;
    logic                 wr_reg;
    logic [REGNOBITS-1:0] wregno;
    logic                 is_load;
    logic                 is_store;
    logic [DBITS-1:0]     wr_val;
    logic                 redirect;
    logic [DBITS-1:0]     target;
  } lat_t;

  op_e              op;
  logic             is_md, is_imm, taken, accept, md_start;
  logic [DBITS-1:0] opb, rs1_imm, br_tgt;
  lat_t             c, lat, skid, md_info, md_out;
  logic             skid_full;
  state_e           state, state_n;
  logic [CW-1:0]    cnt;
  logic [DBITS-1:0] md_a, md_b, md_acc;
  logic [DBITS:0]   rem_sh, diff;

  assign op     = op_e'(de_op);
  assign is_md  = op inside {OP_MUL, OP_DIVU, OP_REMU};
  assign is_imm = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
                             OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU};

  // Single-cycle result for whatever decode presents.
  // NOTE: every variable gets a default at the top of the block so that no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    opb          = is_imm ? de_imm : de_rs2_val;
    rs1_imm      = de_rs1_val + de_imm;
    br_tgt       = de_pc + de_imm;
    taken        = 1'b0;
    c            = '0;
    c.valid      = 1'b1;
    c.inst       = de_inst;
    c.pc         = de_pc;
    c.op         = de_op;
    c.inst_count = de_inst_count;
    c.wr_reg     = de_wr_reg;
    c.wregno     = de_wregno;
    c.wr_val     = de_rs2_val;
    case (op)
      OP_ADD, OP_ADDI:   c.aluout = de_rs1_val + opb;
      OP_SUB:            c.aluout = de_rs1_val - opb;
      OP_AND, OP_ANDI:   c.aluout = de_rs1_val & opb;
      OP_OR, OP_ORI:     c.aluout = de_rs1_val | opb;
      OP_XOR, OP_XORI:   c.aluout = de_rs1_val ^ opb;
      OP_SLL, OP_SLLI:   c.aluout = de_rs1_val << opb[4:0];
      OP_SRL, OP_SRLI:   c.aluout = de_rs1_val >> opb[4:0];
      OP_SRA, OP_SRAI:   c.aluout = $unsigned($signed(de_rs1_val) >>> opb[4:0]);
      OP_SLT, OP_SLTI:   c.aluout = {{(DBITS-1){1'b0}}, $signed(de_rs1_val) < $signed(opb)};
      OP_SLTU, OP_SLTIU: c.aluout = {{(DBITS-1){1'b0}}, de_rs1_val < opb};
      OP_LUI:            c.aluout = de_imm;
      OP_AUIPC:          c.aluout = de_pc + de_imm;
      OP_LW: begin
        c.aluout  = rs1_imm;
        c.is_load = 1'b1;
      end
      OP_SW: begin
        c.aluout   = rs1_imm;
        c.is_store = 1'b1;
      end
      OP_BEQ:  begin taken = de_rs1_val == de_rs2_val;                   c.wr_reg = 1'b0; end
      OP_BNE:  begin taken = de_rs1_val != de_rs2_val;                   c.wr_reg = 1'b0; end
      OP_BLT:  begin taken = $signed(de_rs1_val) < $signed(de_rs2_val);  c.wr_reg = 1'b0; end
      OP_BGE:  begin taken = $signed(de_rs1_val) >= $signed(de_rs2_val); c.wr_reg = 1'b0; end
      OP_BLTU: begin taken = de_rs1_val < de_rs2_val;                    c.wr_reg = 1'b0; end
      OP_BGEU: begin taken = de_rs1_val >= de_rs2_val;                   c.wr_reg = 1'b0; end
      OP_JAL: begin
        taken    = 1'b1;
        c.aluout = de_pc + DBITS'(4);
      end
      OP_JALR: begin
        taken    = 1'b1;
        c.aluout = de_pc + DBITS'(4);
        br_tgt   = {rs1_imm[DBITS-1:1], 1'b0};
      end
      default: ;
    endcase
    c.redirect = taken;
    c.target   = taken ? br_tgt : '0;
  end

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor if that does not borrow. A zero
  // divisor never borrows, which naturally yields all-ones / the dividend.
  always_comb begin
    rem_sh = {md_acc, md_a[DBITS-1]};
    diff   = rem_sh - {1'b0, md_b};
    md_out = md_info;
    md_out.aluout = (op_e'(md_info.op) == OP_DIVU) ? md_a : md_acc;
  end

  // An instruction accepted in DONE cannot enter the latch at that edge
  // (the MD result does), so it waits one cycle in the skid register while
  // decode is held off.
  assign de_ready = (state != S_BUSY) && !skid_full;
  assign accept   = de_ready && de_valid && !lat.redirect;
  assign md_start = accept && is_md;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (md_start) state_n = S_BUSY;
      S_BUSY: if (cnt == CNT_LAST) state_n = S_DONE;
      S_DONE: state_n = md_start ? S_BUSY : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat       <= '0;
      skid      <= '0;
      skid_full <= 1'b0;
      md_info   <= '0;
      md_a      <= '0;
      md_b      <= '0;
      md_acc    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_BUSY: begin
          lat <= '0;
          cnt <= cnt + 1'b1;
          if (op_e'(md_info.op) == OP_MUL) begin
            if (md_b[0]) md_acc <= md_acc + md_a;
            md_a <= md_a << 1;
            md_b <= md_b >> 1;
          end else if (!diff[DBITS]) begin
            md_acc <= diff[DBITS-1:0];
            md_a   <= {md_a[DBITS-2:0], 1'b1};
          end else begin
            md_acc <= rem_sh[DBITS-1:0];
            md_a   <= {md_a[DBITS-2:0], 1'b0};
          end
        end
        S_DONE: begin
          lat <= md_out;
          if (accept && !is_md) begin
            skid      <= c;
            skid_full <= 1'b1;
          end
        end
        default: begin
          if (skid_full) begin
            lat       <= skid;
            skid_full <= 1'b0;
          end else if (accept && !is_md) begin
            lat <= c;
          end else begin
            lat <= '0;
          end
        end
      endcase
      if (md_start) begin
        md_info <= c;
        md_a    <= de_rs1_val;
        md_b    <= de_rs2_val;
        md_acc  <= '0;
        cnt     <= '0;
      end
    end
  end

  assign agex_valid      = lat.valid;
  assign agex_inst       = lat.inst;
  assign agex_pc         = lat.pc;
  assign agex_op         = lat.op;
  assign agex_inst_count = lat.inst_count;
  assign agex_aluout     = lat.aluout;
  assign agex_wr_reg     = lat.wr_reg;
  assign agex_wregno     = lat.wregno;
  assign agex_is_load    = lat.is_load;
  assign agex_is_store   = lat.is_store;
  assign agex_wr_val     = lat.wr_val;
  assign br_redirect     = lat.redirect;
  assign br_target       = lat.target;

endmodule

// File: tb/tb_agex_md_stage.sv
// Self-checking bench for agex_md_stage: a table of single-cycle vectors
// followed by hand-written sequences for squash, MD timing and reset abort.

module tb_agex_md_stage;
  import agex_pkg::*;

  logic                clk, reset;
  logic                de_valid, de_wr_reg, de_ready;
  logic [31:0]         de_inst, de_pc, de_inst_count, de_rs1_val, de_rs2_val, de_imm;
  logic [IOPBITS-1:0]  de_op, agex_op;
  logic [4:0]          de_wregno, agex_wregno;
  logic                agex_valid, agex_wr_reg, agex_is_load, agex_is_store, br_redirect;
  logic [31:0]         agex_inst, agex_pc, agex_inst_count, agex_aluout, agex_wr_val, br_target;

  int n_pass  = 0;
  int n_total = 0;

  agex_md_stage dut (
    .clk(clk), .reset(reset),
    .de_valid(de_valid), .de_inst(de_inst), .de_pc(de_pc), .de_op(de_op),
    .de_inst_count(de_inst_count), .de_rs1_val(de_rs1_val), .de_rs2_val(de_rs2_val),
    .de_imm(de_imm), .de_wr_reg(de_wr_reg), .de_wregno(de_wregno),
    .de_ready(de_ready),
    .agex_valid(agex_valid), .agex_inst(agex_inst), .agex_pc(agex_pc), .agex_op(agex_op),
    .agex_inst_count(agex_inst_count), .agex_aluout(agex_aluout),
    .agex_wr_reg(agex_wr_reg), .agex_wregno(agex_wregno),
    .agex_is_load(agex_is_load), .agex_is_store(agex_is_store),
    .agex_wr_val(agex_wr_val), .br_redirect(br_redirect), .br_target(br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    op_e         op;
    logic [31:0] rs1, rs2, imm, pc;
    logic        in_wr;
    logic [4:0]  wregno;
    logic        chk_alu;
    logic [31:0] alu;
    logic        exp_wr, ld, st, redir;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic present(input op_e op, input logic [31:0] rs1, rs2, imm, pc,
                         input logic wr, input logic [4:0] wregno);
    de_valid      = 1'b1;
    de_op         = op;
    de_rs1_val    = rs1;
    de_rs2_val    = rs2;
    de_imm        = imm;
    de_pc         = pc;
    de_wr_reg     = wr;
    de_wregno     = wregno;
    de_inst       = pc ^ 32'h1357_9BDF;
    de_inst_count = de_inst_count + 1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents an MD op, measures the de_ready low window and checks the result
  // lands exactly one edge after DONE. With follow set, an ADD 2+3 is offered
  // in the DONE cycle and must appear one edge after the MD result.
  task automatic md_check(input string name, input op_e op, input logic [31:0] a, b,
                          input logic [31:0] exp, input logic [4:0] wno, input bit follow);
    int   busy;
    logic bad;
    present(op, a, b, 32'h0, 32'h500, 1'b1, wno);
    tick();                                   // E0
    de_valid = 1'b0;
    busy = 0;
    bad  = 1'b0;
    while (!de_ready && busy < 100) begin
      busy++;
      if (agex_valid) bad = 1'b1;
      tick();
    end
    check({name, " ready-low cycles"}, busy, 32);
    check({name, " bubble while busy"}, bad, 1'b0);
    check({name, " valid in DONE"}, agex_valid, 1'b0);
    if (follow) present(OP_ADD, 32'd2, 32'd3, 32'h0, 32'h504, 1'b1, 5'd9);
    tick();                                   // E0+33
    de_valid = 1'b0;
    check({name, " result valid"}, agex_valid, 1'b1);
    check({name, " result"}, agex_aluout, exp);
    check({name, " wregno"}, agex_wregno, wno);
    check({name, " wr_reg"}, agex_wr_reg, 1'b1);
    if (follow) begin
      tick();                                 // E0+34
      check({name, " follow valid"}, agex_valid, 1'b1);
      check({name, " follow aluout"}, agex_aluout, 32'd5);
      check({name, " follow wregno"}, agex_wregno, 5'd9);
    end
    tick();
    check({name, " drained"}, agex_valid, 1'b0);
  endtask

  initial begin
    int   waited;
    logic seen;

    vecs[0]  = '{OP_ADD,   32'd5,        32'd7,        32'h0,        32'h0,   1'b1, 5'd3, 1'b1, 32'd12,       1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{OP_SUB,   32'd5,        32'd7,        32'h0,        32'h4,   1'b1, 5'd4, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{OP_AND,   32'hF0F0,     32'hFF00,     32'h0,        32'h8,   1'b1, 5'd5, 1'b1, 32'hF000,     1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{OP_OR,    32'hF0F0,     32'hFF00,     32'h0,        32'hC,   1'b1, 5'd6, 1'b1, 32'hFFF0,     1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{OP_XOR,   32'hF0F0,     32'hFF00,     32'h0,        32'h10,  1'b1, 5'd7, 1'b1, 32'h0FF0,     1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{OP_SLL,   32'd1,        32'h24,       32'h0,        32'h14,  1'b1, 5'd8, 1'b1, 32'h10,       1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{OP_SRL,   32'h80000000, 32'd4,        32'h0,        32'h18,  1'b1, 5'd9, 1'b1, 32'h08000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{OP_SRA,   32'h80000000, 32'd4,        32'h0,        32'h1C,  1'b1, 5'd10, 1'b1, 32'hF8000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{OP_SLT,   32'hFFFFFFFF, 32'd1,        32'h0,        32'h20,  1'b1, 5'd11, 1'b1, 32'd1,       1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h24,  1'b1, 5'd12, 1'b1, 32'd0,       1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{OP_ADDI,  32'd10,       32'd99,       32'hFFFFFFFD, 32'h28,  1'b1, 5'd13, 1'b1, 32'd7,       1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{OP_SRAI,  32'h80000000, 32'd0,        32'h21,       32'h2C,  1'b1, 5'd14, 1'b1, 32'hC0000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{OP_LUI,   32'd0,        32'd0,        32'h12345000, 32'h30,  1'b1, 5'd15, 1'b1, 32'h12345000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{OP_AUIPC, 32'd0,        32'd0,        32'h2000,     32'h1000, 1'b1, 5'd16, 1'b1, 32'h3000,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{OP_LW,    32'h200,      32'd0,        32'hFFFFFFFC, 32'h34,  1'b1, 5'd17, 1'b1, 32'h1FC,     1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{OP_SW,    32'h100,      32'hDEADBEEF, 32'd8,        32'h38,  1'b0, 5'd0, 1'b1, 32'h108,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{OP_BEQ,   32'd4,        32'd4,        32'hFFFFFFF8, 32'h40,  1'b1, 5'd1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h38};
    vecs[17] = '{OP_BNE,   32'd4,        32'd4,        32'hFFFFFFF8, 32'h40,  1'b1, 5'd1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[18] = '{OP_BLT,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100, 1'b1, 5'd2, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h120};
    vecs[19] = '{OP_BLTU,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100, 1'b1, 5'd2, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[20] = '{OP_BGE,   32'd1,        32'd1,        32'hFFFFFF00, 32'h200, 1'b1, 5'd2, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h100};
    vecs[21] = '{OP_BGEU,  32'hFFFFFFFF, 32'd1,        32'h10,       32'h0,   1'b1, 5'd2, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h10};
    vecs[22] = '{OP_JAL,   32'd0,        32'd0,        32'h10,       32'h80,  1'b1, 5'd1, 1'b1, 32'h84,       1'b1, 1'b0, 1'b0, 1'b1, 32'h90};
    vecs[23] = '{OP_JALR,  32'h203,      32'd0,        32'd2,        32'h300, 1'b1, 5'd1, 1'b1, 32'h304,      1'b1, 1'b0, 1'b0, 1'b1, 32'h204};

    reset = 1'b0;
    de_valid = 1'b0; de_op = '0; de_rs1_val = '0; de_rs2_val = '0; de_imm = '0;
    de_pc = '0; de_wr_reg = 1'b0; de_wregno = '0; de_inst = '0; de_inst_count = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset valid", agex_valid, 1'b0);
    check("reset aluout", agex_aluout, 32'h0);
    check("reset redirect", br_redirect, 1'b0);
    check("reset target", br_target, 32'h0);
    check("reset de_ready", de_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post-reset de_ready", de_ready, 1'b1);
    check("idle bubble valid", agex_valid, 1'b0);

    // Table-driven single-cycle vectors, each followed by a bubble cycle.
    for (int i = 0; i < 24; i++) begin
      present(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pc,
              vecs[i].in_wr, vecs[i].wregno);
      tick();
      check($sformatf("v%0d valid", i), agex_valid, 1'b1);
      if (vecs[i].chk_alu) check($sformatf("v%0d aluout", i), agex_aluout, vecs[i].alu);
      check($sformatf("v%0d wr_reg", i), agex_wr_reg, vecs[i].exp_wr);
      check($sformatf("v%0d wregno", i), agex_wregno, vecs[i].wregno);
      check($sformatf("v%0d is_load", i), agex_is_load, vecs[i].ld);
      check($sformatf("v%0d is_store", i), agex_is_store, vecs[i].st);
      check($sformatf("v%0d wr_val", i), agex_wr_val, vecs[i].rs2);
      check($sformatf("v%0d pc", i), agex_pc, vecs[i].pc);
      check($sformatf("v%0d inst", i), agex_inst, vecs[i].pc ^ 32'h1357_9BDF);
      check($sformatf("v%0d redirect", i), br_redirect, vecs[i].redir);
      check($sformatf("v%0d target", i), br_target, vecs[i].tgt);
      de_valid = 1'b0;
      tick();
      check($sformatf("v%0d bubble valid", i), agex_valid, 1'b0);
      check($sformatf("v%0d bubble wr_reg", i), agex_wr_reg, 1'b0);
      check($sformatf("v%0d bubble is_store", i), agex_is_store, 1'b0);
      check($sformatf("v%0d bubble redirect", i), br_redirect, 1'b0);
      check($sformatf("v%0d bubble target", i), br_target, 32'h0);
    end

    // Wrong-path squash: ADD offered in the redirect cycle is dropped.
    present(OP_BEQ, 32'd4, 32'd4, 32'hFFFFFFF8, 32'h40, 1'b1, 5'd1);
    tick();
    check("squash redirect", br_redirect, 1'b1);
    check("squash target", br_target, 32'h38);
    present(OP_ADD, 32'd5, 32'd7, 32'h0, 32'h44, 1'b1, 5'd3);
    check("squash de_ready", de_ready, 1'b1);
    tick();
    de_valid = 1'b0;
    check("squash latch valid", agex_valid, 1'b0);
    check("squash wr_reg", agex_wr_reg, 1'b0);
    check("squash redirect one cycle", br_redirect, 1'b0);
    check("squash target cleared", br_target, 32'h0);
    tick();

    // Multi-cycle ops.
    md_check("MUL", OP_MUL, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 5'd20, 1'b1);
    md_check("DIVU", OP_DIVU, 32'd100, 32'd7, 32'd14, 5'd21, 1'b0);
    md_check("REMU", OP_REMU, 32'd100, 32'd7, 32'd2, 5'd22, 1'b0);
    md_check("DIVU0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 5'd23, 1'b0);
    md_check("REMU0", OP_REMU, 32'd9, 32'd0, 32'd9, 5'd24, 1'b0);

    // Asynchronous clear of a live latch entry.
    present(OP_ADD, 32'd5, 32'd7, 32'h0, 32'h600, 1'b1, 5'd3);
    tick();
    de_valid = 1'b0;
    check("pre-reset valid", agex_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async clear valid", agex_valid, 1'b0);
    check("async clear aluout", agex_aluout, 32'h0);
    check("async clear wr_reg", agex_wr_reg, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a MUL aborts it for good.
    tick();
    present(OP_MUL, 32'd6, 32'd7, 32'h0, 32'h700, 1'b1, 5'd25);
    tick();
    de_valid = 1'b0;
    repeat (10) tick();
    check("mid-busy de_ready", de_ready, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("abort de_ready async", de_ready, 1'b1);
    check("abort valid", agex_valid, 1'b0);
    check("abort redirect", br_redirect, 1'b0);
    check("abort target", br_target, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("after abort de_ready", de_ready, 1'b1);
    seen = 1'b0;
    waited = 0;
    while (waited < 40) begin
      if (agex_valid) seen = 1'b1;
      waited++;
      tick();
    end
    check("no aborted result", seen, 1'b0);
    present(OP_ADD, 32'd1, 32'd1, 32'h0, 32'h800, 1'b1, 5'd2);
    tick();
    de_valid = 1'b0;
    check("post-abort ADD valid", agex_valid, 1'b1);
    check("post-abort ADD aluout", agex_aluout, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
